// File: rtl/zzlab_env_axil_master.sv
// ---------------------------------------------------------------------------
// zzlab_env_axil_master
//
// Single-outstanding AXI4-Lite master in front of the env control register
// slave. A host-side agent hands over one command at a time on a
// valid/ready stream. The master runs the matching AXI4-Lite read or write
// and returns a response record: read data, response code and the number of
// cycles the transaction took.
//
// Ports
//   ACLK, ARESET    clock and asynchronous active-high reset
//   ACLK_EN         clock enable; every register holds while it is low
//   cmd_*           command stream in (valid/ready, write flag, address,
//                   write data, write strobes)
//   rsp_*           response stream out (valid/ready, write echo, read data,
//                   BRESP/RRESP, latency in cycles)
//   AW*/W*/B*       AXI4-Lite write address, write data and write response
//   AR*/R*          AXI4-Lite read address and read data
//
// Only C_M_AXI_DATA_WIDTH = 32 is supported. The strobe width follows from
// the data width.
// ---------------------------------------------------------------------------
module zzlab_env_axil_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 5,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_LAT_WIDTH        = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              ACLK_EN,

    // command stream from the host agent
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    // response stream back to the host agent
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic [C_LAT_WIDTH-1:0]            rsp_latency,

    // AXI4-Lite write address channel
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     AWADDR,
    output logic                              AWVALID,
    input  logic                              AWREADY,

    // AXI4-Lite write data channel
    output logic [C_M_AXI_DATA_WIDTH-1:0]     WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   WSTRB,
    output logic                              WVALID,
    input  logic                              WREADY,

    // AXI4-Lite write response channel
    input  logic [1:0]                        BRESP,
    input  logic                              BVALID,
    output logic                              BREADY,

    // AXI4-Lite read address channel
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     ARADDR,
    output logic                              ARVALID,
    input  logic                              ARREADY,

    // AXI4-Lite read data channel
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                        RRESP,
    input  logic                              RVALID,
    output logic                              RREADY
);

    localparam int StrbWidth = C_M_AXI_DATA_WIDTH / 8;

    localparam logic [C_LAT_WIDTH-1:0] LatOne = {{(C_LAT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_LAT_WIDTH-1:0] LatMax = {C_LAT_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_RSP   = 3'd5
    } state_t;

    // -----------------------------------------------------------------------
    // State and datapath registers (_q) with their next-state values (_d)
    // -----------------------------------------------------------------------
    state_t                          state_q,     state_d;
    logic                            write_q,     write_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [StrbWidth-1:0]            wstrb_q,     wstrb_d;
    logic                            aw_done_q,   aw_done_d;
    logic                            w_done_q,    w_done_d;
    logic [C_LAT_WIDTH-1:0]          lat_q,       lat_d;
    logic                            rsp_write_q, rsp_write_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                      rsp_resp_q,  rsp_resp_d;
    logic [C_LAT_WIDTH-1:0]          rsp_lat_q,   rsp_lat_d;

    logic                            aw_hs;
    logic                            w_hs;
    logic                            aw_done_now;
    logic                            w_done_now;
    logic [C_LAT_WIDTH-1:0]          lat_inc;

    // -----------------------------------------------------------------------
    // Outputs are pure decodes of registered state, so no input reaches an
    // output without passing through a flop. Each write channel VALID drops
    // once its sticky done flag is set, i.e. the cycle after its handshake.
    // -----------------------------------------------------------------------
    assign cmd_ready   = (state_q == S_IDLE);
    assign AWVALID     = (state_q == S_WRITE) && !aw_done_q;
    assign WVALID      = (state_q == S_WRITE) && !w_done_q;
    assign BREADY      = (state_q == S_WRESP);
    assign ARVALID     = (state_q == S_RADDR);
    assign RREADY      = (state_q == S_RDATA);
    assign rsp_valid   = (state_q == S_RSP);

    assign AWADDR      = addr_q;
    assign ARADDR      = addr_q;
    assign WDATA       = wdata_q;
    assign WSTRB       = wstrb_q;

    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_latency = rsp_lat_q;

    assign aw_hs       = AWVALID && AWREADY;
    assign w_hs        = WVALID && WREADY;

    // A channel counts as done if it finished earlier or finishes this cycle,
    // which covers AW-first, W-first and simultaneous completion alike.
    assign aw_done_now = aw_done_q || aw_hs;
    assign w_done_now  = w_done_q || w_hs;

    // Latency counter saturates rather than wrapping so that a very slow
    // slave reports "at least this long" instead of a small bogus value.
    assign lat_inc     = (lat_q == LatMax) ? lat_q : (lat_q + LatOne);

    // -----------------------------------------------------------------------
    // Next-state logic. The latency captured into the response is lat_inc,
    // so the B/R handshake cycle itself is included in the count.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        lat_d       = lat_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_lat_d   = rsp_lat_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    write_d   = cmd_write;
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    lat_d     = '0;
                    state_d   = cmd_write ? S_WRITE : S_RADDR;
                end
            end

            S_WRITE: begin
                lat_d     = lat_inc;
                aw_done_d = aw_done_now;
                w_done_d  = w_done_now;
                if (aw_done_now && w_done_now) begin
                    state_d = S_WRESP;
                end
            end

            S_WRESP: begin
                lat_d = lat_inc;
                if (BVALID) begin
                    rsp_write_d = write_q;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = BRESP;
                    rsp_lat_d   = lat_inc;
                    state_d     = S_RSP;
                end
            end

            S_RADDR: begin
                lat_d = lat_inc;
                if (ARREADY) begin
                    state_d = S_RDATA;
                end
            end

            S_RDATA: begin
                lat_d = lat_inc;
                if (RVALID) begin
                    rsp_write_d = write_q;
                    rsp_rdata_d = RDATA;
                    rsp_resp_d  = RRESP;
                    rsp_lat_d   = lat_inc;
                    state_d     = S_RSP;
                end
            end

            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register. Reset drops any in-flight transaction without a
    // response; a low ACLK_EN freezes everything, including the latency
    // count, so disabled cycles never show up in rsp_latency.
    // -----------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            lat_q       <= '0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            rsp_lat_q   <= '0;
        end else if (ACLK_EN) begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            lat_q       <= lat_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_lat_q   <= rsp_lat_d;
        end
    end

endmodule

// File: tb/tb_zzlab_env_axil_master.sv
// ---------------------------------------------------------------------------
// tb_zzlab_env_axil_master
//
// Directed bench for the AXI4-Lite master. A small AXI4-Lite slave model,
// backed by an 8-word register file, answers the master. Its AW/W/AR ready
// delays are configurable per step. A posedge monitor counts handshakes and
// captures the values transported on each channel.
// ---------------------------------------------------------------------------
module tb_zzlab_env_axil_master;

    localparam int AW = 5;
    localparam int LW = 16;

    logic            ACLK;
    logic            ARESET;
    logic            ACLK_EN;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [31:0]     cmd_wdata;
    logic [3:0]      cmd_wstrb;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_write;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [LW-1:0]   rsp_latency;
    logic [AW-1:0]   AWADDR;
    logic            AWVALID;
    logic            AWREADY;
    logic [31:0]     WDATA;
    logic [3:0]      WSTRB;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic            ARVALID;
    logic            ARREADY;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;

    int total = 0;
    int bad   = 0;

    // slave model configuration, set by the directed steps
    int   awDelay;
    int   wDelay;
    int   arDelay;
    logic respErr;

    // handshake monitor results
    int            awHsCount = 0;
    int            wHsCount  = 0;
    int            bHsCount  = 0;
    int            arHsCount = 0;
    int            rHsCount  = 0;
    int            earlyB    = 0;
    int            awAtCmd;
    int            wAtCmd;
    logic [AW-1:0] lastAwAddr = '0;
    logic [AW-1:0] lastArAddr = '0;
    logic [31:0]   lastWData  = '0;
    logic [3:0]    lastWStrb  = '0;

    logic [31:0]   mem [8];

    zzlab_env_axil_master #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (32),
        .C_LAT_WIDTH        (LW)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .ACLK_EN     (ACLK_EN),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_latency (rsp_latency),
        .AWADDR      (AWADDR),
        .AWVALID     (AWVALID),
        .AWREADY     (AWREADY),
        .WDATA       (WDATA),
        .WSTRB       (WSTRB),
        .WVALID      (WVALID),
        .WREADY      (WREADY),
        .BRESP       (BRESP),
        .BVALID      (BVALID),
        .BREADY      (BREADY),
        .ARADDR      (ARADDR),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RDATA       (RDATA),
        .RRESP       (RRESP),
        .RVALID      (RVALID),
        .RREADY      (RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Handshake monitor: samples pre-edge values on every enabled posedge.
    // BREADY while either AW or W of the current command is still missing
    // is counted as an early B phase.
    initial begin
        forever begin
            @(posedge ACLK);
            if (ARESET === 1'b0 && ACLK_EN === 1'b1) begin
                if (BREADY === 1'b1 && (awHsCount == awAtCmd || wHsCount == wAtCmd)) earlyB++;
                if (AWVALID === 1'b1 && AWREADY === 1'b1) begin
                    awHsCount++;
                    lastAwAddr = AWADDR;
                end
                if (WVALID === 1'b1 && WREADY === 1'b1) begin
                    wHsCount++;
                    lastWData = WDATA;
                    lastWStrb = WSTRB;
                end
                if (BVALID === 1'b1 && BREADY === 1'b1) bHsCount++;
                if (ARVALID === 1'b1 && ARREADY === 1'b1) begin
                    arHsCount++;
                    lastArAddr = ARADDR;
                end
                if (RVALID === 1'b1 && RREADY === 1'b1) rHsCount++;
            end
        end
    end

    // Slave model: drives its outputs on the negedge. A ready delay of d
    // means the handshake lands d cycles after VALID first appears. B and R
    // are raised the cycle after the last address/data handshake.
    initial begin
        int awCnt, wCnt, arCnt, awUsed, wUsed, arUsed, bSeen, rSeen;
        awCnt = 0; wCnt = 0; arCnt = 0;
        awUsed = 0; wUsed = 0; arUsed = 0; bSeen = 0; rSeen = 0;
        for (int k = 0; k < 8; k++) mem[k] = {4{8'(k * 4)}};
        mem[4] = 32'h0001_0002;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
        forever begin
            @(negedge ACLK);
            if (ARESET === 1'b1) begin
                AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
                ARREADY = 1'b0; RVALID = 1'b0;
                awCnt = 0; wCnt = 0; arCnt = 0;
                awUsed = awHsCount; wUsed = wHsCount; arUsed = arHsCount;
                bSeen = bHsCount; rSeen = rHsCount;
            end else begin
                if (AWVALID === 1'b1) begin
                    AWREADY = (awCnt >= awDelay);
                    awCnt++;
                end else begin
                    AWREADY = 1'b0;
                    awCnt = 0;
                end
                if (WVALID === 1'b1) begin
                    WREADY = (wCnt >= wDelay);
                    wCnt++;
                end else begin
                    WREADY = 1'b0;
                    wCnt = 0;
                end
                if (ARVALID === 1'b1) begin
                    ARREADY = (arCnt >= arDelay);
                    arCnt++;
                end else begin
                    ARREADY = 1'b0;
                    arCnt = 0;
                end
                if (BVALID && bHsCount != bSeen) begin
                    BVALID = 1'b0;
                    bSeen = bHsCount;
                end else if (!BVALID && awHsCount > awUsed && wHsCount > wUsed) begin
                    awUsed++;
                    wUsed++;
                    for (int b = 0; b < 4; b++)
                        if (lastWStrb[b]) mem[lastAwAddr[4:2]][8*b +: 8] = lastWData[8*b +: 8];
                    BRESP  = respErr ? 2'b10 : 2'b00;
                    BVALID = 1'b1;
                end
                if (RVALID && rHsCount != rSeen) begin
                    RVALID = 1'b0;
                    rSeen = rHsCount;
                end else if (!RVALID && arHsCount > arUsed) begin
                    arUsed++;
                    RDATA  = mem[lastArAddr[4:2]];
                    RRESP  = respErr ? 2'b10 : 2'b00;
                    RVALID = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the directed sequence ended");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_cmd_ready"},   32'(cmd_ready),   32'd1);
        checkOutput({tag, "_awvalid"},     32'(AWVALID),     32'd0);
        checkOutput({tag, "_wvalid"},      32'(WVALID),      32'd0);
        checkOutput({tag, "_bready"},      32'(BREADY),      32'd0);
        checkOutput({tag, "_arvalid"},     32'(ARVALID),     32'd0);
        checkOutput({tag, "_rready"},      32'(RREADY),      32'd0);
        checkOutput({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
        checkOutput({tag, "_rsp_write"},   32'(rsp_write),   32'd0);
        checkOutput({tag, "_rsp_rdata"},   rsp_rdata,        32'd0);
        checkOutput({tag, "_rsp_resp"},    32'(rsp_resp),    32'd0);
        checkOutput({tag, "_rsp_latency"}, 32'(rsp_latency), 32'd0);
        checkOutput({tag, "_awaddr"},      32'(AWADDR),      32'd0);
        checkOutput({tag, "_araddr"},      32'(ARADDR),      32'd0);
        checkOutput({tag, "_wdata"},       WDATA,            32'd0);
        checkOutput({tag, "_wstrb"},       32'(WSTRB),       32'd0);
    endtask

    // Presents one command and returns on the negedge after it was accepted.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge ACLK);
        awAtCmd   = awHsCount;
        wAtCmd    = wHsCount;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        checkOutput("cmd_ready_seen", 32'(cmd_ready), 32'd1);
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    task automatic awaitRsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic consumeRsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
        checkOutput({tag, "_idle_after"}, 32'(cmd_ready), 32'd1);
        checkOutput({tag, "_rsp_dropped"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic runTxn(input string tag, input logic wr, input logic [AW-1:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input logic [31:0] expRdata, input logic [1:0] expResp,
                          input logic [15:0] expLat);
        applyStimulus(wr, addr, data, strb);
        awaitRsp(tag);
        checkOutput({tag, "_write"},   32'(rsp_write),   32'(wr));
        checkOutput({tag, "_rdata"},   rsp_rdata,        expRdata);
        checkOutput({tag, "_resp"},    32'(rsp_resp),    32'(expResp));
        checkOutput({tag, "_latency"}, 32'(rsp_latency), 32'(expLat));
        consumeRsp(tag);
    endtask

    task automatic checkWriteBus(input string tag, input logic [AW-1:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb);
        checkOutput({tag, "_aw_count"}, 32'(awHsCount - awAtCmd), 32'd1);
        checkOutput({tag, "_w_count"},  32'(wHsCount - wAtCmd),   32'd1);
        checkOutput({tag, "_awaddr"},   32'(lastAwAddr),          32'(addr));
        checkOutput({tag, "_wdata"},    lastWData,                data);
        checkOutput({tag, "_wstrb"},    32'(lastWStrb),           32'(strb));
        checkOutput({tag, "_early_b"},  32'(earlyB),              32'd0);
    endtask

    task automatic waitRready(input string tag);
        int n;
        n = 0;
        while (RREADY !== 1'b1 && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        checkOutput({tag, "_rready_seen"}, 32'(RREADY), 32'd1);
    endtask

    initial begin
        ARESET    = 1'b1;
        ACLK_EN   = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        awDelay   = 0;
        wDelay    = 0;
        arDelay   = 0;
        respErr   = 1'b0;
        awAtCmd   = 0;
        wAtCmd    = 0;

        repeat (3) @(negedge ACLK);
        checkReset("por");
        #1 ARESET = 1'b0;

        $display("[TB] read of the version register");
        runTxn("rd_version", 1'b0, 5'h10, 32'h0, 4'h0, 32'h0001_0002, 2'b00, 16'd2);
        checkOutput("rd_version_araddr", 32'(lastArAddr), 32'h10);

        $display("[TB] write with AW then W, then read back");
        awDelay = 0; wDelay = 1;
        runTxn("wr_serial", 1'b1, 5'h14, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 16'd3);
        checkWriteBus("wr_serial", 5'h14, 32'hDEAD_BEEF, 4'hF);
        wDelay = 0;
        runTxn("rd_back", 1'b0, 5'h14, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 16'd2);

        $display("[TB] response backpressure");
        applyStimulus(1'b0, 5'h18, 32'h0, 4'h0);
        awaitRsp("bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            checkOutput("bp_hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_hold_rdata", rsp_rdata, 32'h1818_1818);
            checkOutput("bp_hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        checkOutput("bp_latency", 32'(rsp_latency), 32'd2);
        consumeRsp("bp");

        $display("[TB] AW/W ordering");
        awDelay = 1; wDelay = 0;
        runTxn("ord_w_first", 1'b1, 5'h00, 32'h1111_1111, 4'hF, 32'h0, 2'b00, 16'd3);
        checkWriteBus("ord_w_first", 5'h00, 32'h1111_1111, 4'hF);
        awDelay = 0; wDelay = 0;
        runTxn("ord_same", 1'b1, 5'h04, 32'h2222_2222, 4'hF, 32'h0, 2'b00, 16'd2);
        checkWriteBus("ord_same", 5'h04, 32'h2222_2222, 4'hF);
        awDelay = 5; wDelay = 6;
        runTxn("ord_aw_late", 1'b1, 5'h0C, 32'h3333_3333, 4'hF, 32'h0, 2'b00, 16'd8);
        checkWriteBus("ord_aw_late", 5'h0C, 32'h3333_3333, 4'hF);

        $display("[TB] partial strobes");
        awDelay = 0; wDelay = 0;
        runTxn("wr_strb", 1'b1, 5'h08, 32'hAABB_CCDD, 4'b0101, 32'h0, 2'b00, 16'd2);
        checkWriteBus("wr_strb", 5'h08, 32'hAABB_CCDD, 4'b0101);
        runTxn("rd_strb", 1'b0, 5'h08, 32'h0, 4'h0, 32'h08BB_08DD, 2'b00, 16'd2);

        $display("[TB] error responses");
        respErr = 1'b1;
        runTxn("rd_err", 1'b0, 5'h00, 32'h0, 4'h0, 32'h1111_1111, 2'b10, 16'd2);
        runTxn("wr_err", 1'b1, 5'h0C, 32'h0, 4'h0, 32'h0, 2'b10, 16'd2);
        respErr = 1'b0;

        $display("[TB] clock enable gating during RDATA");
        applyStimulus(1'b0, 5'h04, 32'h0, 4'h0);
        waitRready("en");
        ACLK_EN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            checkOutput("en_hold_rready", 32'(RREADY), 32'd1);
            checkOutput("en_hold_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        ACLK_EN = 1'b1;
        awaitRsp("en");
        checkOutput("en_rdata", rsp_rdata, 32'h2222_2222);
        checkOutput("en_resp", 32'(rsp_resp), 32'd0);
        checkOutput("en_latency", 32'(rsp_latency), 32'd2);
        consumeRsp("en");

        $display("[TB] reset in the middle of a write");
        awDelay = 20; wDelay = 20;
        applyStimulus(1'b1, 5'h10, 32'h5555_5555, 4'hF);
        checkOutput("mid_wvalid_before", 32'(WVALID), 32'd1);
        #2 ARESET = 1'b1;
        #1 checkReset("mid_reset");
        @(negedge ACLK);
        #1 ARESET = 1'b0;
        awDelay = 0; wDelay = 0;
        runTxn("rd_after_reset", 1'b0, 5'h1C, 32'h0, 4'h0, 32'h1C1C_1C1C, 2'b00, 16'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
